// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbitration of execution-unit results onto the single registered writeback port
module wb_port_arbiter #(
  parameter int NUM_UNITS      = 4,
  parameter int LOG2_MAX_IDS   = 3,
  parameter int XLEN           = 32,
  parameter int CONFLICT_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_UNITS-1:0]           unit_valid,
  input  logic [NUM_UNITS*LOG2_MAX_IDS-1:0] unit_id,
  input  logic [NUM_UNITS*XLEN-1:0]      unit_data,
  output logic [NUM_UNITS-1:0]           unit_ack,
  input  logic                           writeback_suppress,
  output logic                           wb_valid,
  output logic [LOG2_MAX_IDS-1:0]        wb_id,
  output logic [XLEN-1:0]                wb_data,
  output logic [CONFLICT_CNT_W-1:0]      conflict_count,
  input  logic                           conflict_clear
);
  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  logic [PW-1:0] rr_ptr, gnt_idx, k;
  logic found, grant, multi;
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    k = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      k = PW'((int'(rr_ptr) + i) % NUM_UNITS);
      if (!found && unit_valid[k]) begin
        found = 1'b1;
        gnt_idx = k;
      end
    end
  end
  assign grant = found && !writeback_suppress && !rst;
  assign unit_ack = grant ? (NUM_UNITS'(1) << gnt_idx) : '0;
  // at least two requesters: clearing the lowest set bit leaves something
  assign multi = |(unit_valid & (unit_valid - NUM_UNITS'(1)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      wb_valid <= 1'b0;
      wb_id <= '0;
      wb_data <= '0;
      conflict_count <= '0;
    end else begin
      wb_valid <= grant;
      if (grant) begin
        rr_ptr <= (gnt_idx == PW'(NUM_UNITS - 1)) ? '0 : gnt_idx + PW'(1);
        wb_id <= unit_id[gnt_idx*LOG2_MAX_IDS +: LOG2_MAX_IDS];
        wb_data <= unit_data[gnt_idx*XLEN +: XLEN];
      end
      conflict_count <= conflict_clear ? '0 :
                        (grant && multi && !(&conflict_count)) ? conflict_count + CONFLICT_CNT_W'(1) :
                        conflict_count;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of the writeback arbiter against a spec-level model
module tb_wb_port_arbiter;
  localparam int N = 4;
  localparam int IW = 3;
  localparam int XW = 32;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] valid = '0;
  logic [N*IW-1:0] id = '0;
  logic [N*XW-1:0] data = '0;
  logic sup = 0, clr = 0;
  logic [N-1:0] ack;
  logic wb_valid;
  logic [IW-1:0] wb_id;
  logic [XW-1:0] wb_data;
  logic [CW-1:0] cnt;
  int n_cmp = 0, n_err = 0;
  int m_ptr = 0, m_cnt = 0;
  logic m_valid = 0;
  logic [IW-1:0] m_id = '0;
  logic [XW-1:0] m_data = '0;
  logic [N-1:0] last_g = '0;

  wb_port_arbiter #(.NUM_UNITS(N), .LOG2_MAX_IDS(IW), .XLEN(XW), .CONFLICT_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .unit_valid(valid), .unit_id(id), .unit_data(data),
    .unit_ack(ack), .writeback_suppress(sup), .wb_valid(wb_valid), .wb_id(wb_id),
    .wb_data(wb_data), .conflict_count(cnt), .conflict_clear(clr));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p, input logic s);
    logic [N-1:0] r;
    r = '0;
    if (s) return r;
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) begin
        r[(p + i) % N] = 1'b1;
        return r;
      end
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_valid = 0; m_id = '0; m_data = '0; last_g = '0;
  endtask

  task automatic tick();
    logic [N-1:0] g;
    g = rr_pick(valid, m_ptr, sup);
    @(posedge clk);
    m_valid = (g != 0);
    for (int k = 0; k < N; k++)
      if (g[k]) begin
        m_ptr = (k + 1) % N;
        m_id = id[k*IW +: IW];
        m_data = data[k*XW +: XW];
      end
    if (clr) m_cnt = 0;
    else if (g != 0 && $countones(valid) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    last_g = g;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; valid = '0; sup = 0; clr = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; valid = '1; #1;
    n_cmp++; if (ack !== '0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", ack); end
    n_cmp++; if ({wb_valid, wb_id, wb_data} !== '0) begin n_err++; $display("FAIL reset_wb got=%b/%h/%h exp=0", wb_valid, wb_id, wb_data); end
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold got=%b exp=0", wb_valid); end
    rst = 0; valid = '0; model_reset();
  endtask

  task automatic test_single();
    valid = 4'b0100; id[2*IW +: IW] = 3'd5; data[2*XW +: XW] = 32'hDEADBEEF; #1;
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL single_ack got=%b exp=0100", ack); end
    tick(); valid = '0;
    n_cmp++; if ({wb_valid, wb_id, wb_data} !== {1'b1, 3'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL single_wb got=%b/%0d/%h exp=1/5/deadbeef", wb_valid, wb_id, wb_data); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0 || cnt !== '0) begin n_err++; $display("FAIL single_after got=%b/%0d exp=0/0", wb_valid, cnt); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < N; k++) id[k*IW +: IW] = IW'(k + 3);
    valid = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (ack !== exp_ack[c]) begin n_err++; $display("FAIL rr_ack c=%0d got=%b exp=%b", c, ack, exp_ack[c]); end
      tick();
      n_cmp++; if (wb_id !== IW'((c % N) + 3) || wb_valid !== 1'b1) begin n_err++; $display("FAIL rr_wb c=%0d got=%0d exp=%0d", c, wb_id, (c % N) + 3); end
      n_cmp++; if (cnt !== CW'(c + 1)) begin n_err++; $display("FAIL rr_cnt c=%0d got=%0d exp=%0d", c, cnt, c + 1); end
    end
    valid = '0;
  endtask

  task automatic test_wrap();
    valid = 4'b1000; tick();
    valid = 4'b0101; #1;
    n_cmp++; if (ack !== 4'b0001) begin n_err++; $display("FAIL wrap_first got=%b exp=0001", ack); end
    tick(); valid = 4'b0100; #1;
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL wrap_second got=%b exp=0100", ack); end
    tick(); valid = '0;
  endtask

  task automatic test_suppress();
    valid = 4'b0001; tick();
    valid = 4'b1010; sup = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (ack !== '0) begin n_err++; $display("FAIL sup_ack c=%0d got=%b exp=0", c, ack); end
      tick();
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL sup_wb c=%0d got=%b exp=0", c, wb_valid); end
    end
    sup = 0; #1;
    n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL sup_rel1 got=%b exp=0010", ack); end
    tick(); valid = 4'b1000; #1;
    n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL sup_rel2 got=%b exp=1000", ack); end
    tick(); valid = '0;
  endtask

  task automatic test_saturation();
    clr = 1; tick(); clr = 0;
    valid = '1;
    for (int c = 0; c < 20; c++) tick();
    n_cmp++; if (cnt !== 4'd15 || cnt !== CW'(m_cnt)) begin n_err++; $display("FAIL sat_cnt got=%0d exp=15", cnt); end
    clr = 1; tick(); clr = 0;
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL clear_cnt got=%0d exp=0", cnt); end
    tick();
    n_cmp++; if (cnt !== 4'd1) begin n_err++; $display("FAIL clear_resume got=%0d exp=1", cnt); end
    valid = '0;
  endtask

  task automatic test_async_reset();
    valid = 4'b0001; data[0 +: XW] = 32'h1234_5678; id[0 +: IW] = 3'd6;
    tick(); valid = '0;
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre got=%b exp=1", wb_valid); end
    #2 rst = 1; #1;
    n_cmp++; if ({wb_valid, wb_id, wb_data} !== '0) begin n_err++; $display("FAIL areset_now got=%b/%0d/%h exp=0", wb_valid, wb_id, wb_data); end
    model_reset();
    @(negedge clk); rst = 0; valid = 4'b0110; #1;
    n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL areset_first got=%b exp=0010", ack); end
    tick(); valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    last_g = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (last_g[k]) valid[k] = 1'b0;
        if (!valid[k] && $urandom_range(0, 9) < 6) begin
          valid[k] = 1'b1;
          id[k*IW +: IW] = IW'($urandom);
          data[k*XW +: XW] = $urandom;
        end
      end
      sup = ($urandom_range(0, 9) < 2);
      clr = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++; if (ack !== rr_pick(valid, m_ptr, sup)) begin n_err++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, ack, rr_pick(valid, m_ptr, sup)); end
      tick();
      n_cmp++; if ({wb_valid, wb_id, wb_data, cnt} !== {m_valid, m_id, m_data, CW'(m_cnt)}) begin
        n_err++; $display("FAIL rand_wb c=%0d got=%b/%0d/%h/%0d exp=%b/%0d/%h/%0d", c, wb_valid, wb_id, wb_data, cnt, m_valid, m_id, m_data, m_cnt);
      end
    end
    valid = '0; sup = 0; clr = 0;
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_round_robin();
    test_wrap();
    test_suppress();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer writeback port among NUM_UNITS execution units (ALU, MUL, DIV, load/store, …).
- Each unit presents a writeback packet: id, valid, 32-bit data. The arbiter grants one unit per cycle using round-robin and acknowledges it.
- The winning packet is registered onto the writeback port, which feeds the register file and the ID tracking logic.
- Honours the global-control writeback_suppress. Keeps a saturating count of cycles in which requesters lost arbitration, for the stats block.

Parameters:
- NUM_UNITS, 4, number of requesting units (2..8).
- LOG2_MAX_IDS, 3, width of instruction ID.
- XLEN, 32, data width.
- CONFLICT_CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- unit_valid  in  NUM_UNITS  unit k has a result pending
- unit_id  in  NUM_UNITS*LOG2_MAX_IDS  ID of unit k's result; slice k at [k*LOG2_MAX_IDS +: LOG2_MAX_IDS]
- unit_data  in  NUM_UNITS*XLEN  result data of unit k; slice k at [k*XLEN +: XLEN]
- unit_ack  out  NUM_UNITS  one-hot grant; unit k's packet is consumed this cycle
- writeback_suppress  in  1  global-control hold; no grants while high
- wb_valid  out  1  registered writeback valid
- wb_id  out  LOG2_MAX_IDS  registered writeback ID
- wb_data  out  XLEN  registered writeback data
- conflict_count  out  CONFLICT_CNT_W  saturating count of cycles with >1 request and a grant
- conflict_clear  in  1  synchronous clear of conflict_count

Behaviour:
- Reset (async, rst=1):
  - wb_valid=0, wb_id=0, wb_data=0, conflict_count=0.
  - Round-robin pointer rr_ptr=0.
  - unit_ack=0 while rst is high.
- Handshake:
  - A unit raises unit_valid with a stable id/data and holds both until it sees unit_ack high at a rising edge.
  - The transfer occurs on the edge where unit_valid&unit_ack are both high.
  - The unit may present a new packet in the next cycle.
- Grant:
  - unit_ack is combinational from unit_valid, rr_ptr and writeback_suppress.
  - The winner is the first k with unit_valid[k]=1, searching k = rr_ptr, rr_ptr+1, …, wrapping modulo NUM_UNITS.
  - unit_ack is at most one-hot, and all-zero when no requests are present or writeback_suppress=1.
- Pointer update:
  - On a grant to unit k, rr_ptr <= (k+1) mod NUM_UNITS. Wrap: k=NUM_UNITS-1 gives 0.
  - No grant: rr_ptr holds.
- Output register, 1-cycle latency:
  - On a grant to k: wb_valid <= 1, wb_id <= unit_id[k], wb_data <= unit_data[k].
  - Otherwise: wb_valid <= 0; wb_id and wb_data hold their previous values.
  - Back-to-back grants give continuous wb_valid, one packet per cycle.
- writeback_suppress:
  - Blocks new grants only.
  - A packet already registered still appears as wb_valid for its one cycle.
  - Pending requests stay pending, with no loss and no reorder per unit.
- Conflicts:
  - Each cycle with a grant and popcount(unit_valid)>=2 increments conflict_count.
  - The count saturates at all-ones.
  - conflict_clear has priority over increment; the count is 0 on the next cycle.
- Fairness: a continuously requesting unit is granted within NUM_UNITS cycles of non-suppressed operation.
- Reset mid-operation: all state returns to reset values immediately. Requests present after reset release are arbitrated starting from unit 0.
- No combinational path from unit_valid to wb_*. The only combinational output is unit_ack.

Test Plan:
- Single requester: unit 2 valid with id=5, data=0xDEADBEEF, held for one cycle.
  - Required: unit_ack=4'b0100 that cycle.
  - Required next cycle: wb_valid=1, wb_id=5, wb_data=0xDEADBEEF. Then wb_valid=0; conflict_count stays 0.
- Round-robin: all 4 units valid continuously, starting from rr_ptr=0.
  - Required: acks 0001,0010,0100,1000,0001 on consecutive cycles; wb_id follows each unit's id one cycle later.
  - Required: conflict_count increments once per cycle.
- Wrap/skip: after a grant to unit 3, units 0 and 2 are valid.
  - Required: unit 0 is granted first, then unit 2 on the next cycle.
- Suppress: units 1 and 3 valid; writeback_suppress=1 for 3 cycles.
  - Required: unit_ack=0 and wb_valid=0 (after any in-flight packet), rr_ptr unchanged.
  - Required after release: unit 1 then unit 3 are granted.
- Saturation/clear:
  - With CONFLICT_CNT_W=4 and 20 conflict cycles, the count reads 15.
  - conflict_clear together with a conflict gives 0 on the next cycle.
- Async reset mid-stream: assert rst between clock edges while wb_valid=1.
  - Required: wb_valid=0, wb_id=0, wb_data=0 immediately.
  - Required after release with units 1 and 2 valid: unit 1 is granted first.
